// File: rtl/ch_bram_responder.sv
// Block-RAM responder for one sdram-style channel (addr/wr/din/rd/dout/busy/refresh).
// Latency: busy rises the edge a request is seen and stays high LATENCY cycles (REFRESH_CYCLES for refresh).
// Backpressure: ch_busy; one-deep request slot (last wins) holds requests arriving while busy.
module ch_bram_responder #(
  parameter int ADDR_WIDTH     = 13,
  parameter int LATENCY        = 4,
  parameter int REFRESH_CYCLES = 6
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic [24:0] ch_addr,
  input  logic        ch_wr,
  input  logic [7:0]  ch_din,
  input  logic        ch_rd,
  output logic [7:0]  ch_dout,
  output logic        ch_busy,
  input  logic        refresh,
  output logic        oor
);

  localparam int DEPTH   = 1 << ADDR_WIDTH;
  localparam int CNT_MAX = (LATENCY > REFRESH_CYCLES) ? LATENCY : REFRESH_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] REF_INIT = CNT_W'(REFRESH_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_REFRESH = 2'd2
  } state_t;

  // Edge detection of the level-style request lines
  logic                  r_wr_q;
  logic                  r_rd_q;
  logic                  w_rise_wr;
  logic                  w_rise_rd;
  logic                  w_rise;

  // One-deep pending request slot
  logic                  r_pend_vld;
  logic                  r_pend_wr;
  logic [ADDR_WIDTH-1:0] r_pend_addr;
  logic [7:0]            r_pend_din;

  // Operands of the access being launched this cycle
  logic                  w_acc_wr;
  logic [ADDR_WIDTH-1:0] w_acc_addr;
  logic [7:0]            w_acc_din;

  // FSM state and next-state
  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic                  r_busy;
  logic                  w_busy_nxt;
  logic                  r_op_wr;
  logic                  w_op_wr_nxt;
  logic                  w_accept;
  logic                  w_dout_ld;

  // Datapath
  logic [7:0]            r_mem [DEPTH];
  logic [7:0]            r_rdata;
  logic [7:0]            r_dout;
  logic                  r_oor;
  logic                  w_oor_hit;

  assign w_rise_wr = ch_wr & ~r_wr_q;
  assign w_rise_rd = ch_rd & ~r_rd_q;
  assign w_rise    = w_rise_wr | w_rise_rd;

  // A write and read rising together: the write wins, the read is dropped.
  // A fresh rise takes precedence over an older slot entry (last wins).
  assign w_acc_wr   = w_rise ? w_rise_wr              : r_pend_wr;
  assign w_acc_addr = w_rise ? ch_addr[ADDR_WIDTH-1:0] : r_pend_addr;
  assign w_acc_din  = w_rise ? ch_din                 : r_pend_din;

  // Upper address bits are ignored for storage but flagged
  assign w_oor_hit = w_rise & (|ch_addr[24:ADDR_WIDTH]);

  assign ch_busy = r_busy;
  assign ch_dout = r_dout;
  assign oor     = r_oor;

  // Register request levels for rising-edge detection
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_q <= 1'b0;
      r_rd_q <= 1'b0;
    end else begin
      r_wr_q <= ch_wr;
      r_rd_q <= ch_rd;
    end
  end

  // Pending slot: fill on a rise unless that rise is launched directly; clear on launch
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_vld  <= 1'b0;
      r_pend_wr   <= 1'b0;
      r_pend_addr <= '0;
      r_pend_din  <= 8'h00;
    end else if (w_accept) begin
      r_pend_vld  <= 1'b0;
    end else if (w_rise) begin
      r_pend_vld  <= 1'b1;
      r_pend_wr   <= w_rise_wr;
      r_pend_addr <= ch_addr[ADDR_WIDTH-1:0];
      r_pend_din  <= ch_din;
    end
  end

  // FSM state register, busy counter and current-op flag
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_op_wr <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= w_busy_nxt;
      r_op_wr <= w_op_wr_nxt;
    end
  end

  // FSM next-state: refresh beats pending work; busy drops for at least one IDLE cycle
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_busy_nxt  = r_busy;
    w_op_wr_nxt = r_op_wr;
    w_accept    = 1'b0;
    w_dout_ld   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (refresh) begin
          w_state_nxt = ST_REFRESH;
          w_cnt_nxt   = REF_INIT;
          w_busy_nxt  = 1'b1;
        end else if (r_pend_vld || w_rise) begin
          w_state_nxt = ST_ACCESS;
          w_cnt_nxt   = LAT_INIT;
          w_busy_nxt  = 1'b1;
          w_op_wr_nxt = w_acc_wr;
          w_accept    = 1'b1;
        end
      end
      ST_ACCESS: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_IDLE;
          w_busy_nxt  = 1'b0;
          w_dout_ld   = ~r_op_wr;
        end else begin
          w_cnt_nxt   = r_cnt - CNT_W'(1);
        end
      end
      ST_REFRESH: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_IDLE;
          w_busy_nxt  = 1'b0;
        end else begin
          w_cnt_nxt   = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // Storage: writes commit and reads are fetched at the launch edge; contents survive reset
  always_ff @(posedge clk_sys) begin
    if (w_accept) begin
      if (w_acc_wr) begin
        r_mem[w_acc_addr] <= w_acc_din;
      end else begin
        r_rdata <= r_mem[w_acc_addr];
      end
    end
  end

  // Read data becomes visible on the same edge busy falls; writes/refresh leave it alone
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_dout <= 8'h00;
    end else if (w_dout_ld) begin
      r_dout <= r_rdata;
    end
  end

  // Sticky out-of-range flag for captured requests with nonzero upper address bits
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_oor <= 1'b0;
    end else if (w_oor_hit) begin
      r_oor <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ch_bram_responder.sv
// Directed bench for ch_bram_responder: reset, aliasing, wr/rd collision, refresh priority,
// bulk write/readback and reset during a read access.
// All expected values are hand-derived constants or simple functions of the address.
module tb_ch_bram_responder;

  localparam int LAT = 4;
  localparam int REF = 6;

  logic        clk_sys;
  logic        rst_n;
  logic [24:0] ch_addr;
  logic        ch_wr;
  logic [7:0]  ch_din;
  logic        ch_rd;
  logic [7:0]  ch_dout;
  logic        ch_busy;
  logic        refresh;
  logic        oor;

  int n_chk  = 0;
  int n_fail = 0;

  ch_bram_responder #(
    .ADDR_WIDTH     (13),
    .LATENCY        (LAT),
    .REFRESH_CYCLES (REF)
  ) u_dut (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .ch_addr (ch_addr),
    .ch_wr   (ch_wr),
    .ch_din  (ch_din),
    .ch_rd   (ch_rd),
    .ch_dout (ch_dout),
    .ch_busy (ch_busy),
    .refresh (refresh),
    .oor     (oor)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called #1 after a rising edge with the block idle. Raises the request lines,
  // drops them after the capture edge and counts cycles busy is seen high.
  task automatic do_req(input bit wr, input bit rd, input logic [24:0] a,
                        input logic [7:0] d, output int cyc);
    ch_addr = a;
    ch_din  = d;
    ch_wr   = wr;
    ch_rd   = rd;
    @(posedge clk_sys); #1;
    ch_wr = 1'b0;
    ch_rd = 1'b0;
    cyc   = 0;
    while (ch_busy === 1'b1 && cyc < 100) begin
      cyc++;
      @(posedge clk_sys); #1;
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          c;
    int          errs_b;
    int          errs_d;
    logic [11:0] pat;

    // ---- Test 1: reset with ch_rd held high -> exactly one read
    rst_n   = 1'b0;
    ch_addr = 25'h0000000;
    ch_din  = 8'h00;
    ch_wr   = 1'b0;
    ch_rd   = 1'b1;
    refresh = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    chk("rst_busy", ch_busy, 1'b0);
    chk("rst_dout", ch_dout, 8'h00);
    chk("rst_oor",  oor,     1'b0);
    @(negedge clk_sys);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_sys); #1;
      chk($sformatf("t1_busy_%0d", i), ch_busy, (i < LAT) ? 1'b1 : 1'b0);
    end
    ch_rd = 1'b0;
    @(posedge clk_sys); #1;
    chk("t1_oor", oor, 1'b0);

    // ---- Test 2: aliased write/read, oor sets
    do_req(1'b1, 1'b0, 25'h0002000, 8'hA5, c);
    chk("t2_wr_busy_cycles", c, LAT);
    chk("t2_oor", oor, 1'b1);
    do_req(1'b0, 1'b1, 25'h0002000, 8'h00, c);
    chk("t2_rd_busy_cycles", c, LAT);
    chk("t2_rd_dout", ch_dout, 8'hA5);
    do_req(1'b0, 1'b1, 25'h0000000, 8'h00, c);
    chk("t2_alias_dout", ch_dout, 8'hA5);

    // ---- Test 3: write and read rise together -> write only
    do_req(1'b1, 1'b1, 25'h0000010, 8'h3C, c);
    chk("t3_busy_cycles", c, LAT);
    chk("t3_dout_unchanged", ch_dout, 8'hA5);
    repeat (3) @(posedge clk_sys);
    #1;
    chk("t3_no_second_op", ch_busy, 1'b0);
    do_req(1'b0, 1'b1, 25'h0000010, 8'h00, c);
    chk("t3_readback", ch_dout, 8'h3C);
    chk("t3_oor_sticky", oor, 1'b1);

    // ---- Test 4: refresh with a simultaneous write -> refresh 6, gap 1, write 4
    ch_addr = 25'h0000020;
    ch_din  = 8'h5A;
    ch_wr   = 1'b1;
    refresh = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk_sys); #1;
      pat[i] = ch_busy;
      if (i == 0) begin
        ch_wr   = 1'b0;
        refresh = 1'b0;
      end
    end
    chk("t4_busy_pattern", pat, 12'h7BF);
    chk("t4_dout_unchanged", ch_dout, 8'h3C);
    do_req(1'b0, 1'b1, 25'h0000020, 8'h00, c);
    chk("t4_readback", ch_dout, 8'h5A);

    // ---- Test 5: 1200 writes then 1200 reads with the wait-busy-low handshake
    errs_b = 0;
    for (int i = 0; i < 1200; i++) begin
      do_req(1'b1, 1'b0, 25'(i), 8'(i), c);
      if (c != LAT) errs_b++;
    end
    chk("t5_wr_busy_errs", errs_b, 0);
    errs_b = 0;
    errs_d = 0;
    for (int i = 0; i < 1200; i++) begin
      do_req(1'b0, 1'b1, 25'(i), 8'h00, c);
      if (c != LAT) errs_b++;
      if (ch_dout !== 8'(i)) errs_d++;
    end
    chk("t5_rd_busy_errs", errs_b, 0);
    chk("t5_readback_errs", errs_d, 0);
    chk("t5_last_dout", ch_dout, 8'hAF);

    // ---- Test 6: reset during a read access
    do_req(1'b1, 1'b0, 25'h00003FF, 8'hC3, c);
    ch_addr = 25'h00003FF;
    ch_rd   = 1'b1;
    @(posedge clk_sys); #1;
    ch_rd = 1'b0;
    chk("t6_busy_before_rst", ch_busy, 1'b1);
    @(posedge clk_sys); #1;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", ch_busy, 1'b0);
    chk("t6_rst_dout", ch_dout, 8'h00);
    chk("t6_rst_oor",  oor,     1'b0);
    @(negedge clk_sys);
    rst_n = 1'b1;
    @(posedge clk_sys); #1;
    @(posedge clk_sys); #1;
    chk("t6_idle_after_rst", ch_busy, 1'b0);
    do_req(1'b0, 1'b1, 25'h00003FF, 8'h00, c);
    chk("t6_rereq_busy_cycles", c, LAT);
    chk("t6_rereq_dout", ch_dout, 8'hC3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
